// File: rtl/nibble_io_responder.sv
// Peripheral on a 4-bit processor I/O pair: toggle-handshake commands in, ack toggle + 3-bit response out, backed by a small FIFO.
// Optional input synchronizer: define NIBBLE_IO_SYNC_EN when o_reg comes from an unrelated clock.
module nibble_io_responder #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ACK_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] o_reg,
  output logic [3:0] i_pins,
  output logic [4:0] fifo_count,
  output logic       busy,
  output logic       ovf
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNW = 5;
  localparam int unsigned DW  = 4;

  localparam logic [2:0] OP_PUSH   = 3'b001;
  localparam logic [2:0] OP_POP    = 3'b010;
  localparam logic [2:0] OP_STATUS = 3'b011;
  localparam logic [2:0] OP_CLEAR  = 3'b100;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_DATA = 2'd1, DELAY = 2'd2} state_t;

  state_t          state, next_state;
  logic [3:0]      cmd_c;
  logic            prev_req;
  logic            pending_push;
  logic [DW-1:0]   dly_cnt;
  logic [2:0]      resp_q;
  logic [PW-1:0]   wptr, rptr;
  logic [2:0]      mem [DEPTH];

  logic            accept_c, ack_c, full_c, empty_c;
  logic [2:0]      resp_c;
  logic            do_push_c, do_pop_c, do_clear_c, set_ovf_c, set_pend_c, clr_pend_c;

`ifdef NIBBLE_IO_SYNC_EN
  logic [3:0] sync1, sync2;

  // Two-flop synchronizer for the whole command nibble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= o_reg;
      sync2 <= sync1;
    end
  end
  assign cmd_c = sync2;
`else
  assign cmd_c = o_reg;
`endif

  assign full_c   = (fifo_count == CNW'(DEPTH));
  assign empty_c  = (fifo_count == '0);
  assign accept_c = ((state == IDLE) || (state == WAIT_DATA)) && (cmd_c[3] != prev_req);
  assign ack_c    = (state == DELAY) && (dly_cnt == DW'(ACK_DELAY));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE, WAIT_DATA: if (accept_c) next_state = DELAY;
      DELAY:           if (ack_c) next_state = pending_push ? WAIT_DATA : IDLE;
      default:         next_state = IDLE;
    endcase
  end

  // Symbol decode: response and FIFO actions for an accepted symbol
  always_comb begin
    resp_c     = 3'b000;
    do_push_c  = 1'b0;
    do_pop_c   = 1'b0;
    do_clear_c = 1'b0;
    set_ovf_c  = 1'b0;
    set_pend_c = 1'b0;
    clr_pend_c = 1'b0;
    if (accept_c) begin
      if (state == WAIT_DATA) begin
        clr_pend_c = 1'b1;
        if (full_c) begin
          set_ovf_c = 1'b1;
          resp_c    = 3'b111;
        end else begin
          do_push_c = 1'b1;
        end
      end else begin
        case (cmd_c[2:0])
          OP_PUSH:   set_pend_c = 1'b1;
          OP_POP: begin
            if (!empty_c) begin
              do_pop_c = 1'b1;
              resp_c   = mem[rptr];
            end
          end
          OP_STATUS: resp_c = {ovf, full_c, empty_c};
          OP_CLEAR:  do_clear_c = 1'b1;
          default:   resp_c = 3'b000;
        endcase
      end
    end
  end

  // Handshake, ack timing and FIFO bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_req     <= 1'b0;
      pending_push <= 1'b0;
      busy         <= 1'b0;
      dly_cnt      <= '0;
      resp_q       <= '0;
      i_pins       <= '0;
      wptr         <= '0;
      rptr         <= '0;
      fifo_count   <= '0;
      ovf          <= 1'b0;
    end else begin
      if (accept_c) begin
        prev_req <= cmd_c[3];
        busy     <= 1'b1;
        dly_cnt  <= '0;
        resp_q   <= resp_c;
      end
      if (state == DELAY) begin
        if (ack_c) begin
          i_pins <= {~i_pins[3], resp_q};
          busy   <= 1'b0;
        end else begin
          dly_cnt <= dly_cnt + DW'(1);
        end
      end
      if (set_pend_c)      pending_push <= 1'b1;
      else if (clr_pend_c) pending_push <= 1'b0;
      if (do_clear_c) begin
        wptr       <= '0;
        rptr       <= '0;
        fifo_count <= '0;
        ovf        <= 1'b0;
      end
      if (do_push_c) begin
        wptr       <= wptr + PW'(1);
        fifo_count <= fifo_count + CNW'(1);
      end
      if (do_pop_c) begin
        rptr       <= rptr + PW'(1);
        fifo_count <= fifo_count - CNW'(1);
      end
      if (set_ovf_c) ovf <= 1'b1;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wptr] <= cmd_c[2:0];
  end

endmodule

// File: doc/nibble_io_responder.md
Name: nibble_io_responder

Overview:
- Peripheral at the far end of the microprocessor's 4-bit I/O pair.
- Consumes the processor's o_reg output as a toggle-handshake command stream and drives the processor's i_pins input with an acknowledge toggle plus 3-bit response.
- Backs the link with a small 3-bit-wide FIFO so programs can push, pop and query data through the nibble port.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- ACK_DELAY, 1, extra idle cycles between command execution and the ack toggle; 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- o_reg  input  4  from processor: [3] request toggle, [2:0] symbol.
- i_pins  output  4  to processor: [3] ack toggle, [2:0] response.
- fifo_count  output  5  current FIFO occupancy, 0..DEPTH.
- busy  output  1  high while a symbol is accepted but not yet acked.
- ovf  output  1  sticky overflow flag.

Behaviour:
- Reset (reset=0, async): i_pins=4'b0000, prev_req=0, FIFO empty, fifo_count=0, ovf=0, busy=0, pending_push=0, state=IDLE. Reset mid-transaction aborts it; no ack is issued.
- Request detect: in IDLE or WAIT_DATA, a rising clk edge with o_reg[3]!=prev_req accepts the symbol. On that edge prev_req<=o_reg[3], the symbol executes, busy<=1, and the state moves to DELAY.
- Toggles while in DELAY are not sampled. prev_req is held, so a premature toggle is accepted on the first edge back in IDLE/WAIT_DATA.
- DELAY: counts ACK_DELAY cycles. On the following edge, i_pins[2:0]<=resp and i_pins[3]<=~i_pins[3] together, and busy<=0.
- Ack timing: acceptance at edge T gives the ack at edge T+1+ACK_DELAY.
- Next state after ack: WAIT_DATA if pending_push=1, else IDLE.
- Opcodes, accepted in IDLE:
  - 000 NOP: resp 000.
  - 001 PUSH: pending_push<=1, resp 000.
  - 010 POP: if not empty, resp=head and read pointer advances; if empty, resp 000 and no change.
  - 011 STATUS: resp={ovf,full,empty}, sampled at the accept edge.
  - 100 CLEAR: pointers reset, count 0, ovf 0, resp 000.
  - 101..111: reserved, treated as NOP, resp 000.
- WAIT_DATA: the accepted symbol is data, never an opcode. pending_push<=0.
  - Not full: write, count+1, resp 000.
  - Full: data dropped, ovf<=1, resp 111.
- FIFO pointers: log2(DEPTH) bits, wrap modulo DEPTH. full when count==DEPTH, empty when count==0. Only one FIFO op per accepted symbol, so simultaneous push/pop cannot occur.
- fifo_count and ovf update on the accept edge. i_pins changes only on the ack edge.

Optional Feature:
- Macro: NIBBLE_IO_SYNC_EN.
- Defined: o_reg passes through a 2-flop synchronizer, both flops reset to 0, before request detect. Acceptance occurs 2 cycles later than the raw toggle, so raw toggle before edge T gives the ack at edge T+3+ACK_DELAY. Used when the processor runs on an unrelated clock.
- Undefined: o_reg is sampled directly and the processor must share clk.

Test Plan:
- Reset with o_reg=0: i_pins=0000, fifo_count=0, ovf=0, busy=0. Drive o_reg=4'b1011 (STATUS) -> with ACK_DELAY=1, i_pins=4'b1001 two edges after accept.
- PUSH data 5, i.e. o_reg 1001 then 0101 after ack -> acks 1000 then 0000; fifo_count=1. Then POP via 1010 -> i_pins=1101, fifo_count=0.
- Push 8 values 1..7,0 then a 9th value 6 -> 9th data ack resp 111, ovf=1, fifo_count=8. STATUS -> resp 110. Pops return 1,2,...,7,0 in order.
- POP on empty FIFO -> resp 000, fifo_count stays 0. CLEAR after overflow -> ovf=0, STATUS resp 001.
- Toggle o_reg[3] again while busy=1 -> ignored until ack, then accepted on the next edge; exactly two acks observed.
- Assert reset low mid-DELAY of a PUSH -> i_pins=0000 immediately and fifo_count=0. No ack after release; pending_push is cleared, so the next symbol is decoded as an opcode.
